inst_writer: RTL and testbench

INST_WRITER -- requirements
Module: inst_writer

---
 rtl/inst_pkg.sv | 31 +++
 rtl/inst_pack.sv | 34 +++
 rtl/inst_writer.sv | 116 +++++++++++
 tb/tb_inst_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared opcode constants and instruction-type decode for the instruction writer slice.
package inst_pkg;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_ALUI = 7'h13;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_SB   = 7'h63;
  localparam logic [6:0] OP_UJ   = 7'h6F;

  typedef enum logic [2:0] {
    TYPE_R,
    TYPE_I,
    TYPE_S,
    TYPE_SB,
    TYPE_UJ,
    TYPE_BAD
  } inst_type_e;

  function automatic inst_type_e decode_type(input logic [6:0] opcode);
    case (opcode)
      OP_R:             return TYPE_R;
      OP_LOAD, OP_ALUI: return TYPE_I;
      OP_S:             return TYPE_S;
      OP_SB:            return TYPE_SB;
      OP_UJ:            return TYPE_UJ;
      default:          return TYPE_BAD;
    endcase
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational encoder: packs instruction fields into a 32-bit word by opcode type.
module inst_pack
  import inst_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  inst_type_e itype;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    itype   = decode_type(opcode);
    word    = '0;
    illegal = 1'b0;
    case (itype)
      TYPE_R:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      TYPE_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
      TYPE_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      // Branch and jump offsets are halfword-aligned, so imm[0] is dropped.
      TYPE_SB: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      TYPE_UJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_writer.sv
// Accepts instruction field sets, encodes them and writes them to sequential memory words.
// Optional read-back check after each write is enabled by defining INST_WRITER_VERIFY_EN.
module inst_writer
  import inst_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h28,
  parameter int          MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        read,
  output logic        write,
  input  logic [31:0] memOut,
  output logic        err,
  output logic        full
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] FULL  = 2'd3;
`ifdef INST_WRITER_VERIFY_EN
  localparam logic [1:0] VERIFY = 2'd2;
`endif

  localparam int            CW   = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WORDS - 1);

  logic [1:0]    state;
  logic [31:0]   ptr;
  logic [31:0]   word_q;
  logic [31:0]   word;
  logic [CW-1:0] count;
  logic          illegal;
  logic          err_q;
  logic          accept;
  logic          step;

  inst_pack u_pack (
    .opcode  (opcode),
    .rd      (rd),
    .funct3  (funct3),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct7  (funct7),
    .imm     (imm),
    .word    (word),
    .illegal (illegal)
  );

  assign accept = in_valid & in_ready;

  // step marks the last cycle of a word's memory transaction; the pointer advances there.
`ifdef INST_WRITER_VERIFY_EN
  assign step = (state == VERIFY);
  assign read = (state == VERIFY);
`else
  logic unused_memout;
  assign step          = (state == WRITE);
  assign read          = 1'b0;
  assign unused_memout = ^memOut;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= BASE_ADDR;
      word_q <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              word_q <= word;
              state  <= WRITE;
            end
          end
        end
`ifdef INST_WRITER_VERIFY_EN
        WRITE:  state <= VERIFY;
        VERIFY: if (memOut != word_q) err_q <= 1'b1;
`endif
        default: ;
      endcase
      if (step) begin
        ptr   <= ptr + 32'd4;
        count <= count + CW'(1);
        state <= (count == LAST) ? FULL : IDLE;
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign write    = (state == WRITE);
  assign full     = (state == FULL);
  assign address  = ptr;
  assign memIn    = word_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_writer.sv
// Self-checking bench for inst_writer: spec-level encoder model, write scoreboard and directed cases.
// Builds with or without INST_WRITER_VERIFY_EN; the read-back cases run only when it is defined.
module tb_inst_writer;

  localparam logic [31:0] BASE = 32'h28;
  localparam int          MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [20:0] imm;
  logic [31:0] address;
  logic [31:0] memIn;
  logic        read;
  logic        write;
  logic [31:0] memOut;
  logic        err;
  logic        full;

  inst_writer #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rd       (rd),
    .funct3   (funct3),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct7   (funct7),
    .imm      (imm),
    .address  (address),
    .memIn    (memIn),
    .read     (read),
    .write    (write),
    .memOut   (memOut),
    .err      (err),
    .full     (full)
  );

  always #5 clk = ~clk;

  // Small memory model; corrupt flips bit 0 on read-back.
  logic [31:0] mem [0:63];
  logic        corrupt = 1'b0;
  always @(posedge clk) if (write === 1'b1) mem[address[7:2]] <= memIn;
  assign memOut = mem[address[7:2]] ^ {31'b0, corrupt};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: expected writes, write pointer, word count and error pulses.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] m_ptr;
  int          m_count;
  int          exp_errs = 0;
  int          err_seen = 0;
  int          wr_seen  = 0;
  logic [31:0] last_addr, last_data;
  logic        prev_write = 1'b0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] ref_encode(input logic [31:0] op, rdv, f3, r1, r2, f7, im,
                                             output bit ok);
    ok = 1'b1;
    case (op)
      32'h33:         return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
      32'h03, 32'h13: return ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
      32'h23:         return (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                             | ((im & 32'h1F) << 7) | op;
      32'h63:         return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                             | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                             | (((im >> 11) & 1) << 7) | op;
      32'h6F:         return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                             | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12)
                             | (rdv << 7) | op;
      default: begin
        ok = 1'b0;
        return 32'h0;
      end
    endcase
  endfunction

  // Compare process: every observed write must match the head of the model queue.
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (prev_write) begin
`ifdef INST_WRITER_VERIFY_EN
      check("read_after_write", {31'b0, read}, 32'd1);
      check("verify_addr", address, prev_addr);
`else
      check("read_idle", {31'b0, read}, 32'd0);
`endif
    end
    prev_write = (write === 1'b1);
    prev_addr  = address;
    if (write === 1'b1) begin
      wr_seen++;
      last_addr = address;
      last_data = memIn;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: write=1 at %h data %h, required no write", address, memIn);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", address, e.addr);
        check("write_data", memIn, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_ptr   = BASE;
    m_count = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rdv, input logic [2:0] f3,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                            input logic [20:0] im);
    opcode = op; rd = rdv; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
  endtask

  // Presents one field set, updates the model on acceptance and waits for the outcome.
  task automatic send(input logic [6:0] op, input logic [4:0] rdv, input logic [2:0] f3,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                      input logic [20:0] im, input bit chk, input logic [31:0] lit_data,
                      input logic [31:0] lit_addr, input string name);
    bit          ok;
    logic [31:0] w;
    int          n;
    set_fields(op, rdv, f3, r1, r2, f7, im);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      check({name, "_accept_timeout"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    w = ref_encode(32'(op), 32'(rdv), 32'(f3), 32'(r1), 32'(r2), 32'(f7), 32'(im), ok);
    if (ok && m_count < MAXW) begin
      exp_q.push_back('{addr: m_ptr, data: w});
      m_ptr += 4;
      m_count++;
`ifdef INST_WRITER_VERIFY_EN
      if (corrupt) exp_errs++;
`endif
    end
    if (!ok) exp_errs++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      check({name, "_err_pulse"}, {31'b0, err}, 32'd1);
      @(posedge clk);
      #1;
      check({name, "_err_one_cycle"}, {31'b0, err}, 32'd0);
      tick();
      return;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_write_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    if (chk) begin
      check({name, "_lit_data"}, last_data, lit_data);
      check({name, "_lit_addr"}, last_addr, lit_addr);
    end
  endtask

  initial begin
    int wr_before;
    set_fields(7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 21'h0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    m_ptr    = BASE;
    m_count  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset values while rst_n is held low.
    tick();
    check("rst_address", address, 32'h28);
    check("rst_memIn", memIn, 32'h0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_read", {31'b0, read}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);
    tick();

    // R-type
    send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0, 1'b1, 32'h002081B3, 32'h28, "r_add");

    // I-type then S-type from a fresh pointer
    do_reset();
    send(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 21'hFFF, 1'b1, 32'hFFF00293, 32'h28, "i_addi");
    send(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 21'd8, 1'b1, 32'h0020A423, 32'h2C, "s_sw");

    // SB-type then UJ-type
    send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 21'd16, 1'b1, 32'h00208863, 32'h30, "sb_beq");
    send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 21'd8, 1'b1, 32'h008000EF, 32'h34, "uj_jal");

    // Illegal opcode: err pulse, no write, pointer unchanged for the next legal word
    wr_before = wr_seen;
    send(7'h7F, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 21'd0, 1'b0, 32'h0, 32'h0, "illegal");
    check("illegal_no_write", 32'(wr_seen), 32'(wr_before));
    send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0, 1'b1, 32'h002081B3, 32'h38, "after_illegal");

    // Fill to MAX_WORDS
    do_reset();
    for (int i = 0; i < MAXW; i++)
      send(7'h13, 5'(i), 3'd0, 5'd2, 5'd0, 7'd0, 21'(i * 3), 1'b0, 32'h0, 32'h0, "fill");
    check("fill_last_addr", last_addr, 32'h64);
    tick();
    tick();
    check("full_level", {31'b0, full}, 32'd1);
    check("full_not_ready", {31'b0, in_ready}, 32'd0);
    wr_before = wr_seen;
    set_fields(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0);
    in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    check("extra_no_write", 32'(wr_seen), 32'(wr_before));
    check("full_held", {31'b0, full}, 32'd1);

    // Reset in the middle of a write drops it
    do_reset();
    check("ready_after_full_reset", {31'b0, in_ready}, 32'd1);
    wr_before = wr_seen;
    set_fields(7'h33, 5'd7, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("midwrite_write_hi", {31'b0, write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwrite_write_drop", {31'b0, write}, 32'd0);
    check("midwrite_addr", address, 32'h28);
    check("midwrite_memIn", memIn, 32'h0);
    exp_q.delete();
    m_ptr   = BASE;
    m_count = 0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midwrite_no_write", 32'(wr_seen), 32'(wr_before));

`ifdef INST_WRITER_VERIFY_EN
    // Read-back against a corrupting memory, then a correct one
    do_reset();
    corrupt = 1'b1;
    send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0, 1'b1, 32'h002081B3, 32'h28, "verify_bad");
    repeat (3) tick();
    corrupt = 1'b0;
    send(7'h33, 5'd4, 3'd0, 5'd1, 5'd2, 7'd0, 21'd0, 1'b1, 32'h00208233, 32'h2C, "verify_good");
    repeat (3) tick();
`endif

    repeat (3) tick();
    check("err_pulse_total", 32'(err_seen), 32'(exp_errs));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
